// File: rtl/phyreg_freelist.sv
// Physical register free list: circular FIFO of tags, self-filled after reset, show-ahead alloc_tag.
// alloc_ack is same-cycle combinational; a release into a full list is dropped and flagged sticky.
module phyreg_freelist #(
   parameter int LOG_RF_DEPTH = 32,
   parameter int PHY_RF_DEPTH = 128,
   localparam int FL_DEPTH    = PHY_RF_DEPTH - LOG_RF_DEPTH,
   localparam int TW          = $clog2(PHY_RF_DEPTH),
   localparam int CW          = $clog2(FL_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alloc_req,
   output logic          alloc_ack,
   output logic [TW-1:0] alloc_tag,
   input  logic          rel_valid,
   input  logic [TW-1:0] rel_tag,
   output logic [CW-1:0] free_count,
   output logic          empty,
   output logic          init_done,
   output logic          err_overflow
);

   localparam int PW = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(FL_DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FL_DEPTH);
   localparam logic [TW-1:0] TAG_BASE = TW'(LOG_RF_DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] mem [FL_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;

   logic          wr_en;
   logic [TW-1:0] wr_dat;
   logic          rel_accept;
   logic          rel_drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) state <= INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      alloc_ack  = 1'b0;
      rel_accept = 1'b0;
      rel_drop   = 1'b0;
      wr_en      = 1'b0;
      wr_dat     = rel_tag;
      case (state)
         INIT: begin
            // wr_ptr doubles as the fill index: entry i holds tag LOG_RF_DEPTH+i
            wr_en  = 1'b1;
            wr_dat = TAG_BASE + TW'(wr_ptr);
            if (wr_ptr == PTR_LAST) state_nxt = RUN;
         end
         RUN: begin
            alloc_ack  = alloc_req && (count != '0);
            rel_accept = rel_valid && (count != CNT_FULL);
            rel_drop   = rel_valid && (count == CNT_FULL);
            wr_en      = rel_accept;
         end
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         err_overflow <= 1'b0;
      end else begin
         if (wr_en)     wr_ptr <= ptr_inc(wr_ptr);
         if (alloc_ack) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_en, alloc_ack})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (rel_drop) err_overflow <= 1'b1;
      end
   end

   // No bypass: a release into an empty list only shows up on the following cycle.
   assign alloc_tag  = mem[rd_ptr];
   assign free_count = count;
   assign empty      = (count == '0);
   assign init_done  = (state == RUN);

endmodule

// File: tb/tb_phyreg_freelist.sv
// Directed bench for phyreg_freelist at default parameters (32 logical, 128 physical, 96 free).
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_phyreg_freelist;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic       alloc_ack;
   logic [6:0] alloc_tag;
   logic       rel_valid;
   logic [6:0] rel_tag;
   logic [6:0] free_count;
   logic       empty;
   logic       init_done;
   logic       err_overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   phyreg_freelist #(.LOG_RF_DEPTH(32), .PHY_RF_DEPTH(128)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_ack    (alloc_ack),
      .alloc_tag    (alloc_tag),
      .rel_valid    (rel_valid),
      .rel_tag      (rel_tag),
      .free_count   (free_count),
      .empty        (empty),
      .init_done    (init_done),
      .err_overflow (err_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; alloc_req = 1'b0; rel_valid = 1'b0; rel_tag = '0;
      tick(); tick();
      alloc_req = 1'b1; #1;
      chk("rst_free",  32'(free_count),   0);
      chk("rst_empty", 32'(empty),        1);
      chk("rst_init",  32'(init_done),    0);
      chk("rst_err",   32'(err_overflow), 0);
      chk("rst_ack",   32'(alloc_ack),    0);

      // init phase: requests and releases must be ignored for all 96 fill cycles
      rst = 1'b1; rel_valid = 1'b1; rel_tag = 7'd3;
      for (int i = 0; i < 96; i++) begin
         if (i == 0 || i == 95) begin
            chk("init_busy", 32'(init_done), 0);
            chk("init_ack",  32'(alloc_ack), 0);
         end
         tick();
      end
      alloc_req = 1'b0; rel_valid = 1'b0; #1;
      chk("init_done",  32'(init_done),  1);
      chk("init_free",  32'(free_count), 96);
      chk("init_tag",   32'(alloc_tag),  32);
      chk("init_empty", 32'(empty),      0);

      alloc_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("alloc3_ack", 32'(alloc_ack), 1);
         chk("alloc3_tag", 32'(alloc_tag), 32'(32 + k));
         tick();
      end
      alloc_req = 1'b0; #1;
      chk("alloc3_free", 32'(free_count), 93);

      alloc_req = 1'b1;
      for (int k = 3; k < 96; k++) begin
         #1;
         chk("drain_tag", 32'(alloc_tag), 32'(32 + k));
         tick();
      end
      alloc_req = 1'b0; #1;
      chk("drain_empty", 32'(empty),      1);
      chk("drain_free",  32'(free_count), 0);

      // empty list: same-cycle release must not be bypassed to the requester
      alloc_req = 1'b1; rel_valid = 1'b1; rel_tag = 7'd5; #1;
      chk("nobypass_ack", 32'(alloc_ack), 0);
      tick();
      alloc_req = 1'b0; rel_valid = 1'b0; #1;
      chk("rel5_empty", 32'(empty),      0);
      chk("rel5_tag",   32'(alloc_tag),  5);
      chk("rel5_free",  32'(free_count), 1);

      alloc_req = 1'b1; #1;
      chk("rel5_ack", 32'(alloc_ack), 1);
      tick();
      alloc_req = 1'b0; rel_valid = 1'b1;
      for (int t = 10; t <= 105; t++) begin
         rel_tag = 7'(t);
         tick();
      end
      rel_valid = 1'b0; #1;
      chk("refill_free", 32'(free_count), 96);
      alloc_req = 1'b1;
      for (int t = 10; t <= 105; t++) begin
         #1;
         chk("wrap_tag", 32'(alloc_tag), 32'(t));
         tick();
      end
      #1;
      chk("wrap_empty",     32'(empty),     1);
      chk("wrap_empty_ack", 32'(alloc_ack), 0);
      alloc_req = 1'b0;

      rst = 1'b0; tick(); rst = 1'b1;
      for (int i = 0; i < 96; i++) tick();
      chk("reinit_done", 32'(init_done), 1);

      rel_valid = 1'b1; rel_tag = 7'd7; #1;
      chk("ovf_before", 32'(err_overflow), 0);
      tick();
      rel_valid = 1'b0; #1;
      chk("ovf_set",  32'(err_overflow), 1);
      chk("ovf_free", 32'(free_count),   96);
      tick();
      chk("ovf_held", 32'(err_overflow), 1);
      alloc_req = 1'b1; #1;
      chk("ovf_tag0", 32'(alloc_tag), 32);
      tick();
      chk("ovf_tag1", 32'(alloc_tag), 33);
      tick();
      for (int k = 0; k < 44; k++) tick();
      alloc_req = 1'b0; #1;
      chk("mid_free", 32'(free_count), 50);

      rst = 1'b0; tick(); rst = 1'b1; #1;
      chk("midrst_free",  32'(free_count),   0);
      chk("midrst_init",  32'(init_done),    0);
      chk("midrst_err",   32'(err_overflow), 0);
      chk("midrst_empty", 32'(empty),        1);
      for (int i = 0; i < 95; i++) tick();
      chk("midrst_busy95", 32'(init_done), 0);
      tick();
      chk("midrst_done", 32'(init_done),  1);
      chk("midrst_tag",  32'(alloc_tag),  32);
      chk("midrst_full", 32'(free_count), 96);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
